seq_8bit_multiplier: RTL and testbench

SEQ_8BIT_MULTIPLIER -- requirements
Module: seq_8bit_multiplier

---
 rtl/mul_pkg.sv | 5 +
 rtl/seq_8bit_multiplier.sv | 73 +++++++
 tb/tb_seq_8bit_multiplier.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mul_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam int MUL_WIDTH = 8;
endpackage

// File: rtl/seq_8bit_multiplier.sv
// Unsigned sequential multiplier: one shift-add step per clock, WIDTH steps per product.
module seq_8bit_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] Product,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum;

   // Lower half of acc holds the multiplier; its LSB selects the add, and the
   // extra sum bit keeps the carry that shifts into the top of the accumulator.
   always_comb begin
      addend = acc[0] ? mcand : '0;
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mcand   <= '0;
         acc     <= '0;
         cnt     <= '0;
         Product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand <= A;
                  acc   <= {{WIDTH{1'b0}}, B};
                  cnt   <= CW'(WIDTH);
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= {sum, acc[WIDTH-1:1]};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  Product <= {sum, acc[WIDTH-1:1]};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_8bit_multiplier.sv
// Directed bench for seq_8bit_multiplier: timing, arithmetic, start filtering, async reset.
module tb_seq_8bit_multiplier;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] Product;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   seq_8bit_multiplier #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .Product(Product), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start for one cycle; returns at the first sample point after the capture edge.
   task automatic do_start(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start = 1'b1; A = a; B = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; A = 8'd0; B = 8'd0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (Product !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: Product=%0d busy=%b done=%b, required 0/0/0", Product, busy, done);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b done=%b, required 0/0", busy, done);
      end
   endtask

   // 5*25: busy for 8 cycles, done in the 9th cycle, Product unchanged until then.
   task automatic test_basic();
      int busy_cnt;
      busy_cnt = 0;
      do_start(8'd5, 8'd25);
      n_checks++;
      if (Product !== 16'd0) begin
         n_fail++;
         $display("FAIL product_hold_in_calc: Product=%0d, required 0", Product);
      end
      for (int i = 1; i <= 9; i++) begin
         if (i > 1) @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         n_checks++;
         if (done !== (i == 9)) begin
            n_fail++;
            $display("FAIL basic_done_timing: cycle %0d done=%b, required %b", i, done, (i == 9));
         end
      end
      n_checks++;
      if (Product !== 16'd125) begin
         n_fail++;
         $display("FAIL basic_product: Product=%0d, required 125", Product);
      end
      n_checks++;
      if (busy_cnt != 8) begin
         n_fail++;
         $display("FAIL basic_busy_len: busy cycles=%0d, required 8", busy_cnt);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || Product !== 16'd125) begin
         n_fail++;
         $display("FAIL basic_after_done: done=%b busy=%b Product=%0d, required 0/0/125", done, busy, Product);
      end
   endtask

   task automatic test_back_to_back();
      do_start(8'd13, 8'd28);
      repeat (8) @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || Product !== 16'd364) begin
         n_fail++;
         $display("FAIL b2b_first: done=%b Product=%0d, required 1/364", done, Product);
      end
      // next sample point is the IDLE cycle right after DONE
      do_start(8'd6, 8'd37);
      n_checks++;
      if (busy !== 1'b1 || Product !== 16'd364) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b Product=%0d, required 1/364", busy, Product);
      end
      repeat (8) @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || Product !== 16'd222) begin
         n_fail++;
         $display("FAIL b2b_second: done=%b Product=%0d, required 1/222", done, Product);
      end
      @(negedge clk);
   endtask

   task automatic test_corners();
      do_start(8'd255, 8'd255);
      repeat (8) @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || Product !== 16'd65025) begin
         n_fail++;
         $display("FAIL max_operands: done=%b Product=%0d, required 1/65025", done, Product);
      end
      do_start(8'd0, 8'd37);
      for (int i = 1; i <= 9; i++) begin
         if (i > 1) @(negedge clk);
         n_checks++;
         if (done !== (i == 9) || busy !== (i < 9)) begin
            n_fail++;
            $display("FAIL zero_latency: cycle %0d done=%b busy=%b, required %b/%b", i, done, busy, (i == 9), (i < 9));
         end
      end
      n_checks++;
      if (Product !== 16'd0) begin
         n_fail++;
         $display("FAIL zero_product: Product=%0d, required 0", Product);
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int done_cnt;
      done_cnt = 0;
      do_start(8'd5, 8'd25);
      for (int i = 1; i <= 14; i++) begin
         if (i > 1) @(negedge clk);
         if (i == 3) begin start = 1'b1; A = 8'd9; B = 8'd9; end
         if (i == 4) start = 1'b0;
         if (done === 1'b1) done_cnt++;
         if (i == 9) begin
            n_checks++;
            if (Product !== 16'd125) begin
               n_fail++;
               $display("FAIL ignore_start_product: Product=%0d, required 125", Product);
            end
         end
      end
      n_checks++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_start_single_done: done pulses=%0d busy=%b, required 1/0", done_cnt, busy);
      end
   endtask

   task automatic test_operand_change();
      do_start(8'd200, 8'd3);
      @(negedge clk);
      A = 8'd1; B = 8'd1;
      repeat (7) @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || Product !== 16'd600) begin
         n_fail++;
         $display("FAIL captured_operands: done=%b Product=%0d, required 1/600", done, Product);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_calc();
      int done_cnt;
      done_cnt = 0;
      do_start(8'd200, 8'd200);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || Product !== 16'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_calc: busy=%b Product=%0d done=%b, required 0/0/0", busy, Product, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      n_checks++;
      if (done_cnt != 0) begin
         n_fail++;
         $display("FAIL reset_abort: activity cycles=%0d after abort, required 0", done_cnt);
      end
      do_start(8'd7, 8'd3);
      repeat (8) @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || Product !== 16'd21) begin
         n_fail++;
         $display("FAIL after_reset_product: done=%b Product=%0d, required 1/21", done, Product);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_corners();
      test_ignore_start();
      test_operand_change();
      test_reset_mid_calc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
